// File: rtl/hera_ram_arb.sv
// hera_ram_arb: CPU/host arbiter for the single-port hera_ram, CPU priority with host lock bursts.
// Define HERA_ARB_STARVE_EN to force a host grant after STARVE_MAX denied cycles.
module hera_ram_arb #(
    parameter int ADDR_W     = 11,
    parameter int DATA_W     = 16,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_stall,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    input  logic              host_lock,
    output logic              host_gnt,
    output logic              host_rvalid,
    output logic [DATA_W-1:0] host_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_wren,
    input  logic [DATA_W-1:0] ram_q
);
    typedef enum logic {S_NORM, S_HLOCK} state_t;

    state_t state_q, state_d;
    logic   cpu_rvalid_q, host_rvalid_q;
    logic   force_host;

    if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_starve
        $error("STARVE_MAX must be in 1..15");
    end

`ifdef HERA_ARB_STARVE_EN
    logic [3:0] starve_q, starve_d;
    assign force_host = starve_q == 4'(STARVE_MAX);
    always_comb starve_d = (host_gnt || !host_req) ? 4'd0 :
                           (state_q == S_NORM && !force_host) ? starve_q + 4'd1 : starve_q;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) starve_q <= 4'd0;
        else      starve_q <= starve_d;
    end
`else
    assign force_host = 1'b0;
`endif

    // Grants are gated by rst so they drop the instant reset asserts.
    always_comb begin
        host_gnt  = rst && host_req && (state_q == S_HLOCK || !cpu_req || force_host);
        cpu_gnt   = rst && cpu_req && state_q == S_NORM && !host_gnt;
        cpu_stall = rst && cpu_req && !cpu_gnt;
        state_d   = (host_gnt && host_lock) ? S_HLOCK : S_NORM;
        ram_addr  = host_gnt ? host_addr : cpu_addr;
        ram_data  = host_gnt ? host_wdata : cpu_wdata;
        ram_wren  = (cpu_gnt && cpu_we) || (host_gnt && host_we);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= S_NORM;
            cpu_rvalid_q  <= 1'b0;
            host_rvalid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cpu_rvalid_q  <= cpu_gnt && !cpu_we;
            host_rvalid_q <= host_gnt && !host_we;
        end
    end

    assign cpu_rvalid  = cpu_rvalid_q;
    assign host_rvalid = host_rvalid_q;
    assign cpu_rdata   = ram_q;
    assign host_rdata  = ram_q;
endmodule

// File: tb/tb_hera_ram_arb.sv
// tb_hera_ram_arb: directed + random scoreboard bench for hera_ram_arb with a RAM and arbitration model.
module tb_hera_ram_arb;
    localparam int AW = 11, DW = 16, SMAX = 4;
`ifdef HERA_ARB_STARVE_EN
    localparam bit STARVE = 1'b1;
`else
    localparam bit STARVE = 1'b0;
`endif

    logic clk = 1'b0, rst = 1'b0;
    logic cpu_req = 0, cpu_we = 0, host_req = 0, host_we = 0, host_lock = 0;
    logic [AW-1:0] cpu_addr = '0, host_addr = '0, ram_addr;
    logic [DW-1:0] cpu_wdata = '0, host_wdata = '0, ram_data, ram_q, cpu_rdata, host_rdata;
    logic cpu_gnt, cpu_stall, cpu_rvalid, host_gnt, host_rvalid, ram_wren;

    always #5 clk = ~clk;

    hera_ram_arb #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_lock(host_lock), .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
        .ram_addr(ram_addr), .ram_data(ram_data), .ram_wren(ram_wren), .ram_q(ram_q)
    );

    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (ram_wren) mem[ram_addr] <= ram_data;
        ram_q <= mem[ram_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0, n_fail = 0;
    typedef struct { logic [DW-1:0] d; int c; } exp_t;
    exp_t cq[$], hq[$];
    bit locked = 0;
    int cnt = 0;
    logic last_hg, last_cg, last_cs;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: each read return is popped from the queue of the requester it belongs to.
    always @(posedge clk) begin
        bit ev;
        #1;
        if (rst) begin
            ev = cq.size() > 0 && cq[0].c == cyc;
            chk("cpu_rvalid", cpu_rvalid, ev);
            if (ev) begin
                chk("cpu_rdata", cpu_rdata, cq[0].d);
                void'(cq.pop_front());
            end
            ev = hq.size() > 0 && hq[0].c == cyc;
            chk("host_rvalid", host_rvalid, ev);
            if (ev) begin
                chk("host_rdata", host_rdata, hq[0].d);
                void'(hq.pop_front());
            end
        end
    end

    // One arbitration cycle: drive at negedge, compare grants against the rules, update the model.
    task automatic step(input logic cr, input logic cw, input logic [AW-1:0] ca, input logic [DW-1:0] cd,
                        input logic hr, input logic hw, input logic [AW-1:0] ha, input logic [DW-1:0] hd,
                        input logic hl);
        bit hwin, cwin, frc;
        exp_t e;
        cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
        host_req = hr; host_we = hw; host_addr = ha; host_wdata = hd; host_lock = hl;
        #1;
        frc = STARVE && cnt >= SMAX;
        if (locked) begin
            hwin = hr; cwin = 0;
        end else if (cr && !(frc && hr)) begin
            cwin = 1; hwin = 0;
        end else begin
            cwin = 0; hwin = hr;
        end
        chk("cpu_gnt", cpu_gnt, cwin);
        chk("host_gnt", host_gnt, hwin);
        chk("cpu_stall", cpu_stall, cr && !cwin);
        chk("ram_wren", ram_wren, (cwin && cw) || (hwin && hw));
        chk("ram_addr", ram_addr, hwin ? ha : ca);
        chk("ram_data", ram_data, hwin ? hd : cd);
        e.c = cyc + 1;
        if (cwin) begin
            if (cw) ref_mem[ca] = cd;
            else begin e.d = ref_mem[ca]; cq.push_back(e); end
        end
        if (hwin) begin
            if (hw) ref_mem[ha] = hd;
            else begin e.d = ref_mem[ha]; hq.push_back(e); end
        end
        cnt = (hr && !hwin) ? (cnt < SMAX ? cnt + 1 : cnt) : 0;
        locked = hwin && hl;
        last_hg = host_gnt; last_cg = cpu_gnt; last_cs = cpu_stall;
        @(negedge clk);
    endtask

    task automatic idle();
        step(0, 0, '0, '0, 0, 0, '0, '0, 0);
    endtask

    initial begin
        int first, ng, ns;
        bit hp, hr, hw, hl;
        logic [AW-1:0] ha;
        logic [DW-1:0] hd;
        for (int i = 0; i < (1 << AW); i++) begin mem[i] = '0; ref_mem[i] = '0; end
        cpu_req = 1; host_req = 1; host_lock = 1;
        #1;
        chk("rst_cpu_gnt", cpu_gnt, 0);
        chk("rst_host_gnt", host_gnt, 0);
        chk("rst_cpu_stall", cpu_stall, 0);
        chk("rst_ram_wren", ram_wren, 0);
        chk("rst_rvalid", {cpu_rvalid, host_rvalid}, 0);
        @(negedge clk); @(negedge clk);
        rst = 1;

        step(1, 1, 11'h005, 16'h1234, 0, 0, '0, '0, 0);
        step(1, 0, 11'h005, '0, 0, 0, '0, '0, 0);
        idle();

        step(1, 0, 11'h005, '0, 1, 0, 11'h005, '0, 0);
        step(0, 0, '0, '0, 1, 0, 11'h005, '0, 0);
        idle();

        first = 0; ng = 0;
        for (int i = 1; i <= 20; i++) begin
            step(1, 0, 11'(i), '0, 1, 0, 11'h020, '0, 0);
            if (last_hg) begin ng++; if (first == 0) first = i; end
        end
        chk("starve_first_grant", first, STARVE ? 5 : 0);
        chk("starve_grants", ng, STARVE ? 4 : 0);
        if (!STARVE) step(0, 0, '0, '0, 1, 0, 11'h020, '0, 0);
        idle();

        ns = 0;
        step(0, 0, '0, '0, 1, 1, 11'h100, 16'hA000, 1);
        for (int i = 1; i < 4; i++) begin
            step(1, 0, 11'h005, '0, 1, 1, 11'(32'h100 + i), 16'(32'hA000 + i), i < 3);
            ns += int'(last_cs);
        end
        chk("burst_stall_cycles", ns, 3);
        step(1, 0, 11'h005, '0, 0, 0, '0, '0, 0);
        chk("cpu_after_burst", last_cg, 1);
        for (int i = 0; i < 4; i++) begin
            chk("burst_mem", mem[11'(32'h100 + i)], 16'(32'hA000 + i));
            step(1, 0, 11'(32'h100 + i), '0, 0, 0, '0, '0, 0);
        end
        idle();

        step(0, 0, '0, '0, 1, 0, 11'h100, '0, 1);
        cpu_req = 1; cpu_we = 0; host_req = 1; host_we = 0; host_addr = 11'h101; host_lock = 1;
        #1;
        chk("hlock_host_gnt", host_gnt, 1);
        chk("hlock_cpu_stall", cpu_stall, 1);
        rst = 0;
        cq.delete(); hq.delete(); locked = 0; cnt = 0;
        #1;
        chk("arst_host_gnt", host_gnt, 0);
        chk("arst_cpu_gnt", cpu_gnt, 0);
        chk("arst_host_rvalid", host_rvalid, 0);
        chk("arst_cpu_stall", cpu_stall, 0);
        @(posedge clk); #1;
        chk("arst_host_rvalid_edge", host_rvalid, 0);
        chk("arst_ram_wren", ram_wren, 0);
        @(negedge clk);
        rst = 1;
        step(1, 0, 11'h100, '0, 1, 0, 11'h101, '0, 1);
        chk("post_rst_cpu_gnt", last_cg, 1);
        step(0, 0, '0, '0, 1, 0, 11'h101, '0, 0);

        hp = 0; hr = 0; hw = 0; hl = 0; ha = '0; hd = '0;
        for (int i = 0; i < 600; i++) begin
            if (!hp) begin
                hr = $urandom_range(0, 1) == 1;
                hw = $urandom_range(0, 1) == 1;
                hl = $urandom_range(0, 2) != 0;
                ha = 11'($urandom_range(0, 15));
                hd = 16'($urandom);
            end
            step($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 11'($urandom_range(0, 15)),
                 16'($urandom), hr, hw, ha, hd, hl);
            hp = hr && !last_hg;
        end
        if (hp) step(0, 0, '0, '0, hr, hw, ha, hd, 0);
        idle(); idle();
        chk("cpu_queue_drained", cq.size(), 0);
        chk("host_queue_drained", hq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
